// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: owns the PC and drives the combinational ROM (rom_addr/rom_read_enable), fills IF/ID, and handles stall/flush/redirect/halt/out-of-range plus a fetch counter.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ROM_DEPTH = 256,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt_req,
  output logic        rom_read_enable,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        halted,
  output logic        fetch_oob,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);
  typedef enum logic {RUN, HALTED} state_t;
  localparam logic [31:0] DEPTH = 32'(ROM_DEPTH);
  state_t state, state_next;
  logic [31:0] pc;
  logic in_range, go, fetch, stop, oob_hit, bubble;
  assign rom_addr = pc;
  assign in_range = (pc >> 2) < DEPTH;
  assign rom_read_enable = state == RUN && in_range && !stall;
  assign halted = state == HALTED;
  assign go = state == RUN && !redirect_valid && !flush && !stall;
  assign stop = go && (halt_req || !in_range);
  assign fetch = go && !halt_req && in_range;
  assign oob_hit = go && !halt_req && !in_range;
  assign bubble = redirect_valid || (state == RUN && flush) || stop;
  always_comb begin
    state_next = redirect_valid ? RUN : stop ? HALTED : state;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else state <= state_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      if_id_valid <= 1'b0;
      if_id_pc <= 32'd0;
      if_id_inst <= NOP_INST;
      fetch_oob <= 1'b0;
      misalign_err <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      misalign_err <= redirect_valid && redirect_target[1:0] != 2'b00;
      if (redirect_valid) pc <= {redirect_target[31:2], 2'b00};
      else if (fetch) pc <= pc + 32'd4;
      if (fetch) begin
        if_id_valid <= 1'b1;
        if_id_pc <= pc;
        if_id_inst <= rom_inst;
        fetch_count <= fetch_count + 32'd1;
      end else if (bubble) begin
        if_id_valid <= 1'b0;
        if_id_inst <= NOP_INST;
      end
      if (oob_hit) fetch_oob <= 1'b1;
    end
  end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: scoreboard bench for inst_fetch_unit with a behavioural ROM and PC model.
module tb_inst_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, flush = 1'b0, redirect_valid = 1'b0, halt_req = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic rom_read_enable, if_id_valid, halted, fetch_oob, misalign_err;
  logic [31:0] rom_addr, rom_inst, if_id_pc, if_id_inst, fetch_count;
  logic [31:0] rom [256];
  logic [31:0] m_pc, m_cnt;
  logic [63:0] exp_q [$];
  logic [63:0] e;
  int n_cmp = 0, n_bad = 0;
  inst_fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target), .halt_req(halt_req),
    .rom_read_enable(rom_read_enable), .rom_addr(rom_addr), .rom_inst(rom_inst),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_inst(if_id_inst),
    .halted(halted), .fetch_oob(fetch_oob), .misalign_err(misalign_err), .fetch_count(fetch_count)
  );
  always #5 clk = ~clk;
  assign rom_inst = rom_addr[31:10] == 22'd0 ? rom[rom_addr[9:2]] : 32'hDEAD_BEEF;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    m_pc = 32'd0;
    m_cnt = 32'd0;
    #1;
    n_cmp++; if (rom_addr !== m_pc) begin n_bad++; $display("FAIL reset_pc got %h want %h", rom_addr, m_pc); end
    n_cmp++; if (if_id_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", if_id_valid); end
    n_cmp++; if (if_id_inst !== NOP || if_id_pc !== 32'd0) begin n_bad++; $display("FAIL reset_ifid got %h/%h want 0/%h", if_id_pc, if_id_inst, NOP); end
    n_cmp++; if ({halted, fetch_oob, misalign_err} !== 3'b000 || fetch_count !== 32'd0) begin n_bad++; $display("FAIL reset_flags got h%b o%b m%b c%0d want 0", halted, fetch_oob, misalign_err, fetch_count); end
    n_cmp++; if (rom_read_enable !== 1'b1) begin n_bad++; $display("FAIL reset_ren got %b want 1", rom_read_enable); end
  endtask
  task automatic test_fetch(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({m_pc, rom[m_pc[9:2]]});
      tick;
      m_pc += 32'd4;
      m_cnt += 32'd1;
      n_cmp++;
      if (if_id_valid !== 1'b1 || exp_q.size() == 0) begin
        n_bad++; $display("FAIL fetch_valid got %b (queue %0d) want 1", if_id_valid, exp_q.size());
      end else begin
        e = exp_q.pop_front();
        n_cmp++; if ({if_id_pc, if_id_inst} !== e) begin n_bad++; $display("FAIL fetch_data got %h/%h want %h/%h", if_id_pc, if_id_inst, e[63:32], e[31:0]); end
      end
    end
    n_cmp++; if (fetch_count !== m_cnt) begin n_bad++; $display("FAIL fetch_count got %0d want %0d", fetch_count, m_cnt); end
    n_cmp++; if (rom_addr !== m_pc) begin n_bad++; $display("FAIL fetch_pc got %h want %h", rom_addr, m_pc); end
  endtask
  task automatic test_stall;
    stall = 1'b1;
    #1;
    n_cmp++; if (rom_read_enable !== 1'b0) begin n_bad++; $display("FAIL stall_ren got %b want 0", rom_read_enable); end
    for (int i = 0; i < 2; i++) begin
      tick;
      n_cmp++; if (rom_addr !== m_pc) begin n_bad++; $display("FAIL stall_pc got %h want %h", rom_addr, m_pc); end
      n_cmp++; if (if_id_valid !== 1'b1 || if_id_pc !== m_pc - 32'd4 || if_id_inst !== rom[m_pc[9:2] - 8'd1]) begin n_bad++; $display("FAIL stall_ifid got %b/%h/%h want 1/%h", if_id_valid, if_id_pc, if_id_inst, m_pc - 32'd4); end
      n_cmp++; if (fetch_count !== m_cnt) begin n_bad++; $display("FAIL stall_count got %0d want %0d", fetch_count, m_cnt); end
    end
    stall = 1'b0;
  endtask
  task automatic test_redirect;
    redirect_valid = 1'b1; flush = 1'b1; stall = 1'b1; redirect_target = 32'h40;
    tick;
    redirect_valid = 1'b0; flush = 1'b0; stall = 1'b0;
    m_pc = 32'h40;
    n_cmp++; if (rom_addr !== m_pc) begin n_bad++; $display("FAIL redir_pc got %h want %h", rom_addr, m_pc); end
    n_cmp++; if (if_id_valid !== 1'b0 || if_id_inst !== NOP) begin n_bad++; $display("FAIL redir_bubble got %b/%h want 0/%h", if_id_valid, if_id_inst, NOP); end
    n_cmp++; if (misalign_err !== 1'b0 || fetch_count !== m_cnt) begin n_bad++; $display("FAIL redir_flags got m%b c%0d want m0 c%0d", misalign_err, fetch_count, m_cnt); end
    test_fetch(1);
  endtask
  task automatic test_misalign;
    redirect_valid = 1'b1; redirect_target = 32'h22;
    tick;
    redirect_valid = 1'b0;
    m_pc = 32'h20;
    n_cmp++; if (rom_addr !== m_pc) begin n_bad++; $display("FAIL mis_pc got %h want %h", rom_addr, m_pc); end
    n_cmp++; if (misalign_err !== 1'b1) begin n_bad++; $display("FAIL mis_pulse got %b want 1", misalign_err); end
    test_fetch(1);
    n_cmp++; if (misalign_err !== 1'b0) begin n_bad++; $display("FAIL mis_clear got %b want 0", misalign_err); end
  endtask
  task automatic test_flush;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    n_cmp++; if (if_id_valid !== 1'b0 || if_id_inst !== NOP) begin n_bad++; $display("FAIL flush_bubble got %b/%h want 0/%h", if_id_valid, if_id_inst, NOP); end
    n_cmp++; if (rom_addr !== m_pc || fetch_count !== m_cnt) begin n_bad++; $display("FAIL flush_hold got %h/%0d want %h/%0d", rom_addr, fetch_count, m_pc, m_cnt); end
    test_fetch(2);
  endtask
  task automatic test_oob;
    redirect_valid = 1'b1; redirect_target = 32'h3FC;
    tick;
    redirect_valid = 1'b0;
    m_pc = 32'h3FC;
    test_fetch(1);
    tick;
    n_cmp++; if (halted !== 1'b1 || fetch_oob !== 1'b1) begin n_bad++; $display("FAIL oob_flags got h%b o%b want h1 o1", halted, fetch_oob); end
    n_cmp++; if (if_id_valid !== 1'b0 || if_id_inst !== NOP) begin n_bad++; $display("FAIL oob_bubble got %b/%h want 0/%h", if_id_valid, if_id_inst, NOP); end
    n_cmp++; if (rom_addr !== 32'h400 || rom_read_enable !== 1'b0 || fetch_count !== m_cnt) begin n_bad++; $display("FAIL oob_hold got %h ren%b c%0d want 400 ren0 c%0d", rom_addr, rom_read_enable, fetch_count, m_cnt); end
    redirect_valid = 1'b1; redirect_target = 32'h0;
    tick;
    redirect_valid = 1'b0;
    m_pc = 32'h0;
    n_cmp++; if (halted !== 1'b0 || fetch_oob !== 1'b1 || rom_addr !== m_pc) begin n_bad++; $display("FAIL oob_exit got h%b o%b pc %h want h0 o1 pc 0", halted, fetch_oob, rom_addr); end
    test_fetch(1);
  endtask
  task automatic test_halt;
    redirect_valid = 1'b1; redirect_target = 32'h10;
    tick;
    redirect_valid = 1'b0; halt_req = 1'b1;
    tick;
    m_pc = 32'h10;
    for (int i = 0; i < 5; i++) begin
      flush = i[0]; stall = i[1];
      tick;
      n_cmp++; if (halted !== 1'b1 || rom_addr !== m_pc || if_id_valid !== 1'b0) begin n_bad++; $display("FAIL halt_hold got h%b pc %h v%b want h1 pc %h v0", halted, rom_addr, if_id_valid, m_pc); end
      n_cmp++; if (rom_read_enable !== 1'b0 || fetch_count !== m_cnt) begin n_bad++; $display("FAIL halt_ren got ren%b c%0d want ren0 c%0d", rom_read_enable, fetch_count, m_cnt); end
    end
    rst = 1'b1;
    tick;
    rst = 1'b0; flush = 1'b0; stall = 1'b0; halt_req = 1'b0;
    m_pc = 32'h0;
    m_cnt = 32'h0;
    n_cmp++; if (rom_addr !== m_pc || halted !== 1'b0 || fetch_oob !== 1'b0 || fetch_count !== 32'd0) begin n_bad++; $display("FAIL halt_rst got pc %h h%b o%b c%0d want 0", rom_addr, halted, fetch_oob, fetch_count); end
    n_cmp++; if (if_id_valid !== 1'b0 || if_id_inst !== NOP || if_id_pc !== 32'd0) begin n_bad++; $display("FAIL halt_rst_ifid got %b/%h/%h want 0/0/%h", if_id_valid, if_id_pc, if_id_inst, NOP); end
    test_fetch(2);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0101);
    test_reset;
    test_fetch(2);
    test_stall;
    test_fetch(2);
    test_redirect;
    test_misalign;
    test_flush;
    test_oob;
    test_halt;
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
